// File: rtl/link_tx_scheduler.sv
// Serial link transmit scheduler: trains the link with BC comma frames, then
// round-robin multiplexes four 8-bit lanes onto a 2-bit serial lane.
module link_tx_scheduler #(
    parameter int N_TRAIN     = 4,
    parameter int SYNC_PERIOD = 16
) (
    input  logic        clk16,
    input  logic        reset16,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  gnt,
    output logic [1:0]  serial,
    output logic        frame_start,
    output logic        link_active,
    output logic [7:0]  drop_cnt,
    output logic        fsm_state
);

    localparam int TW = (N_TRAIN > 1) ? $clog2(N_TRAIN) : 1;
    localparam int SW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [TW-1:0] TRAIN_LAST = TW'(N_TRAIN - 1);
    localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_PERIOD - 1);
    localparam logic [7:0]    COMMA      = 8'hBC;

    typedef enum logic {TRAIN = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [1:0]    slot;
    logic [7:0]    sh;
    logic [TW-1:0] train_cnt;
    logic [SW-1:0] sync_cnt;
    logic [1:0]    ptr;

    logic          arb_slot;
    logic          arb_valid;
    logic          take;
    logic [1:0]    arb_lane;
    logic [1:0]    cand;
    logic [7:0]    lane_word;
    logic [7:0]    next_word;

    // Round-robin search starts just after the last winner; ptr itself is checked last.
    always_comb begin
        arb_valid = 1'b0;
        arb_lane  = ptr;
        cand      = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!arb_valid && req[cand]) begin
                arb_valid = 1'b1;
                arb_lane  = cand;
            end
        end
    end

    always_comb begin
        arb_slot  = (slot == 2'd3) &&
                    ((state == TRAIN) ? (train_cnt == TRAIN_LAST) : (sync_cnt != SYNC_LAST));
        take      = reset16 && arb_slot && arb_valid;
        lane_word = data_in[{arb_lane, 3'b000} +: 8];
        next_word = take ? lane_word : COMMA;
        gnt       = take ? (4'b0001 << arb_lane) : 4'b0000;
    end

    assign serial      = sh[7:6];
    assign frame_start = (slot == 2'd0);
    assign link_active = (state == RUN);
    assign fsm_state   = state;

    always_ff @(posedge clk16) begin
        if (!reset16) begin
            slot      <= 2'd0;
            sh        <= COMMA;
            state     <= TRAIN;
            train_cnt <= '0;
            sync_cnt  <= '0;
            ptr       <= 2'd3;
            drop_cnt  <= 8'd0;
        end else begin
            slot <= slot + 2'd1;
            if (slot == 2'd3) begin
                sh <= next_word;
                if (take) begin
                    ptr <= arb_lane;
                    // A granted comma is still sent; the receiver will swallow it.
                    if (lane_word == COMMA && drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                if (state == TRAIN) begin
                    train_cnt <= train_cnt + TW'(1);
                    if (train_cnt == TRAIN_LAST) begin
                        state    <= RUN;
                        sync_cnt <= '0;
                    end
                end else begin
                    if (sync_cnt == SYNC_LAST) begin
                        sync_cnt <= '0;
                    end else begin
                        sync_cnt <= sync_cnt + SW'(1);
                    end
                end
            end else begin
                sh <= {sh[5:0], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Bench for link_tx_scheduler: frame-level reference model of the link schedule,
// plus a serial receiver model feeding an in-order scoreboard of granted words.
module tb_link_tx_scheduler;

    localparam int         N_TRAIN     = 4;
    localparam int         SYNC_PERIOD = 16;
    localparam logic [7:0] COMMA       = 8'hBC;

    logic        clk16 = 1'b0;
    logic        reset16 = 1'b0;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [1:0]  serial;
    logic        frame_start;
    logic        link_active;
    logic [7:0]  drop_cnt;
    logic        fsm_state;

    logic [3:0]  lane_req;
    logic [7:0]  lane_data [4];

    assign req     = lane_req;
    assign data_in = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

    link_tx_scheduler #(.N_TRAIN(N_TRAIN), .SYNC_PERIOD(SYNC_PERIOD)) dut (
        .clk16       (clk16),
        .reset16     (reset16),
        .req         (req),
        .data_in     (data_in),
        .gnt         (gnt),
        .serial      (serial),
        .frame_start (frame_start),
        .link_active (link_active),
        .drop_cnt    (drop_cnt),
        .fsm_state   (fsm_state)
    );

    always #5 clk16 = ~clk16;

    int         n_cmp;
    int         n_err;
    int         cyc;
    int         frame;
    int         mptr;
    int         mdrop;
    int         mode;
    int         grant_lane;
    int         bc_run;
    bit         rx_active;
    bit         capture;
    bit         cur_is_data;
    bit         next_is_data;
    logic [7:0] cur_word;
    logic [7:0] next_word;
    logic [7:0] rx_sh;
    logic [7:0] exp_q [$];
    logic [3:0] gnt_log [$];
    logic [3:0] exp_rr [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d, frame %0d)", tag, got, want, cyc, frame);
        end
    endtask

    function automatic logic [7:0] rand_word();
        if ($urandom_range(0, 7) == 0) return COMMA;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        cyc          = 0;
        frame        = 0;
        mptr         = 3;
        mdrop        = 0;
        cur_word     = COMMA;
        cur_is_data  = 1'b0;
        next_is_data = 1'b0;
        next_word    = COMMA;
        grant_lane   = -1;
        rx_sh        = 8'h00;
        bc_run       = 0;
        rx_active    = 1'b0;
        exp_q.delete();
    endtask

    // Decide the content of frame (frame+1) from the schedule rules.
    task automatic decide(output logic [3:0] eg);
        int n;
        int k;
        int l;
        eg           = 4'b0000;
        grant_lane   = -1;
        next_word    = COMMA;
        next_is_data = 1'b0;
        n = frame + 1;
        if (n < N_TRAIN) return;
        k = n - N_TRAIN;
        if (k > 0 && (k % SYNC_PERIOD) == 0) return;
        for (int d = 1; d <= 4; d++) begin
            l = (mptr + d) % 4;
            if (grant_lane < 0 && lane_req[l]) grant_lane = l;
        end
        if (grant_lane >= 0) begin
            eg           = 4'(1 << grant_lane);
            next_word    = lane_data[grant_lane];
            next_is_data = 1'b1;
            mptr         = grant_lane;
            if (next_word == COMMA) begin
                if (mdrop < 255) mdrop++;
            end else begin
                exp_q.push_back(next_word);
            end
        end
    endtask

    task automatic check_cycle();
        int         s;
        logic [3:0] eg;
        s = cyc % 4;
        check("frame_start", frame_start, (s == 0));
        check("link_active", link_active, (frame >= N_TRAIN));
        check("drop_cnt", drop_cnt, mdrop);
        rx_sh = {rx_sh[5:0], serial};
        eg = 4'b0000;
        if (s == 3) begin
            check("tx_word", rx_sh, cur_word);
            if (rx_sh == COMMA) begin
                bc_run++;
                if (bc_run >= N_TRAIN) rx_active = 1'b1;
            end else begin
                bc_run = 0;
                if (!rx_active) check("rx_active_early", rx_active, 1);
                else if (exp_q.size() == 0) check("rx_q_size", exp_q.size(), 1);
                else check("rx_order", rx_sh, exp_q.pop_front());
            end
            decide(eg);
        end
        check("gnt", gnt, eg);
        if (capture && gnt != 4'b0000) gnt_log.push_back(gnt);
    endtask

    task automatic advance();
        int s;
        s = cyc % 4;
        cyc++;
        if (s == 3) begin
            frame++;
            cur_word    = next_word;
            cur_is_data = next_is_data;
            if (grant_lane >= 0) begin
                case (mode)
                    2: lane_data[2] = 8'($urandom_range(0, 255));
                    4: begin
                        if ($urandom_range(0, 1) == 1) lane_data[grant_lane] = rand_word();
                        else lane_req[grant_lane] = 1'b0;
                    end
                    default: ;
                endcase
            end
            grant_lane = -1;
        end
        if (mode == 4) begin
            for (int l = 0; l < 4; l++) begin
                if (!lane_req[l]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        lane_req[l]  = 1'b1;
                        lane_data[l] = rand_word();
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    lane_req[l] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk16);
        check_cycle();
        @(posedge clk16);
        #1;
        advance();
    endtask

    task automatic run_frames(input int nf);
        repeat (nf * 4) step();
    endtask

    task automatic set_mode(input int m);
        mode = m;
        case (m)
            0: lane_req = 4'b0000;
            1: begin
                lane_req     = 4'b1111;
                lane_data[0] = 8'h11;
                lane_data[1] = 8'h22;
                lane_data[2] = 8'h33;
                lane_data[3] = 8'h44;
            end
            2: begin
                lane_req     = 4'b0100;
                lane_data[2] = 8'($urandom_range(0, 255));
            end
            3: begin
                lane_req     = 4'b0010;
                lane_data[1] = COMMA;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(input int cycles);
        reset16 = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk16);
            check("gnt_in_reset", gnt, 4'b0000);
            if (i > 0) begin
                check("rst_serial", serial, 2'b10);
                check("rst_frame_start", frame_start, 1'b1);
                check("rst_link_active", link_active, 1'b0);
                check("rst_drop_cnt", drop_cnt, 8'd0);
            end
            @(posedge clk16);
            #1;
        end
        reset16 = 1'b1;
        model_reset();
    endtask

    task automatic wait_slot(input int want_slot, input bit need_data, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((cyc % 4) == want_slot && (!need_data || cur_is_data) && frame > N_TRAIN) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(tag, found, 1'b1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        mode      = 0;
        capture   = 1'b0;
        lane_req  = 4'b0000;
        for (int l = 0; l < 4; l++) lane_data[l] = 8'h00;
        exp_rr[0] = 4'b0001;
        exp_rr[1] = 4'b0010;
        exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000;
        exp_rr[4] = 4'b0001;
        model_reset();

        // Training with no requests, then idle comma frames.
        do_reset(3);
        run_frames(8);

        // All lanes requesting: round-robin order from lane 0.
        set_mode(1);
        capture = 1'b1;
        run_frames(12);
        capture = 1'b0;
        check("rr_count", (gnt_log.size() >= 5), 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_log.size()) check("rr_order", gnt_log[i], exp_rr[i]);
        end

        // Single continuous lane, forced sync frames interleaved.
        set_mode(2);
        run_frames(40);

        // Random requests, withdrawals and comma payloads.
        set_mode(4);
        run_frames(200);

        // Reset in slot 2 of a RUN data frame.
        wait_slot(2, 1'b1, "wait_data_slot2");
        do_reset(2);

        // Lane 1 keeps sending commas until drop_cnt saturates.
        set_mode(3);
        run_frames(330);
        check("drop_sat", drop_cnt, 8'hFF);

        // Reset asserted in an arbitration slot with all lanes requesting.
        set_mode(1);
        run_frames(10);
        wait_slot(3, 1'b0, "wait_slot3");
        do_reset(2);

        set_mode(4);
        run_frames(150);
        set_mode(0);
        run_frames(3);
        check("rx_active_end", rx_active, 1'b1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/link_tx_scheduler.md
LINK_TX_SCHEDULER -- requirements
Module: link_tx_scheduler

Interface
REQ-001 Parameter N_TRAIN, default 4, SHALL set the number of BC (8'hBC) training frames sent after reset.
REQ-002 Parameter SYNC_PERIOD, default 16, SHALL set the RUN-state frame period at which one forced BC frame is sent.
REQ-003 clk16  input  1  SHALL be the single clock, at the 16f serial lane rate.
REQ-004 reset16  input  1  SHALL be a synchronous, active-low reset.
REQ-005 req  input  4  SHALL carry one request bit per lane; a lane holds req and its data stable until granted.
REQ-006 data_in  input  32  SHALL carry the lane k payload on bits [8k+7:8k].
REQ-007 gnt  output  4  SHALL be a one-hot grant pulse; gnt[k] high means the lane k word is taken this cycle.
REQ-008 serial  output  2  SHALL be the 2-bit serial lane, MSB pair first, taken directly from the shift register bits [7:6].
REQ-009 frame_start  output  1  SHALL be high in the cycle serial carries bits [7:6] of a frame.
REQ-010 link_active  output  1  SHALL be high while in RUN.
REQ-011 drop_cnt  output  8  SHALL count granted words whose payload equals 8'hBC.

Function
REQ-012 A frame SHALL be 4 cycles; a 2-bit slot counter wraps 0,1,2,3,0; frame_start = (slot==0).
REQ-013 Shift register sh[7:0]: at the edge ending slot 3 it SHALL load the next frame word; at every other edge it SHALL shift left by 2.
REQ-014 State machine: TRAIN (after reset) -> RUN; RUN SHALL persist until reset.
REQ-015 TRAIN: train_cnt SHALL increment at each slot-3 edge; the loaded word SHALL be 8'hBC while train_cnt < N_TRAIN-1.
REQ-016 TRAIN, slot 3, train_cnt == N_TRAIN-1: SHALL arbitrate (REQ-018), load the result, enter RUN, and clear sync_cnt; exactly N_TRAIN BC frames precede the first arbitrated frame.
REQ-017 RUN, slot 3: if sync_cnt == SYNC_PERIOD-1, SHALL load 8'hBC, issue no grant, and clear sync_cnt; otherwise SHALL arbitrate and increment sync_cnt.
REQ-018 Arbitration SHALL be round-robin: search lanes ptr+1, ptr+2, ptr+3, ptr (mod 4), and the first lane with req set wins.
REQ-019 On a win, gnt[k] SHALL be asserted combinationally during that slot-3 cycle only, data_in lane k SHALL be loaded, and ptr SHALL update to k.
REQ-020 When no req bit is set, the scheduler SHALL load 8'hBC (idle), issue no grant, and leave ptr unchanged.
REQ-021 A granted payload of 8'hBC SHALL be sent unchanged and counted as dropped, since the receiver treats it as a comma; drop_cnt SHALL saturate at 255.
REQ-022 gnt SHALL be all-zero in slots 0-2, during forced-sync frames, in TRAIN before the final training slot, and during reset.
REQ-023 A req deasserted before its grant SHALL be ignored without error; a req that stays set after its grant SHALL compete again in the next arbitration.

Reset
REQ-024 Reset values SHALL be: slot 0, sh 8'hBC (serial 2'b10, frame_start 1), state TRAIN, train_cnt 0, sync_cnt 0, ptr 3 (lane 0 has first priority), drop_cnt 0, gnt 0, link_active 0.
REQ-025 Reset asserted mid-frame or mid-RUN SHALL take effect at the next clk16 edge, discard the partial frame, and restart training; no grant SHALL be issued during reset.

Verification
REQ-026 Reset release with no req, N_TRAIN=4 -> serial repeats 10,11,11,00 for 4 frames; link_active rises at the 4th frame's slot-3 edge; idle BC frames follow.
REQ-027 req=4'b1111, lanes hold 8'h11/22/33/44, RUN -> grants in order lane0,1,2,3,0; serial for 8'h11 is 00,01,00,01.
REQ-028 Continuous req on lane 2, SYNC_PERIOD=16 -> every 16th RUN frame is BC with gnt=0; the other 15 frames carry lane 2 data.
REQ-029 Lane 1 payload 8'hBC granted 300 times -> 8'hBC sent each time and drop_cnt saturates at 8'hFF.
REQ-030 reset16 driven low at slot 2 of a RUN data frame -> next cycle shows serial 2'b10, slot 0, link_active 0, gnt 0; training restarts.
REQ-031 A bench model of the serial-to-parallel receiver SHALL check that the receiver goes active after training and that every granted non-BC word appears at the receiver output in order.
